// File: rtl/cond_unit.sv
// cond_unit -- condition evaluation and write/branch gating.
//
// Registers the ALU {N,Z,C,V} flags and checks the instruction condition
// field against the *registered* flags. The result gates the decoder's raw
// PC-source, register-write and memory-write strobes.
//
// Optional macro COND_PERF_EN adds saturating executed/skipped instruction
// counters. Without the macro, exec_cnt and skip_cnt are tied to 0.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   en              instruction valid; no state change when 0
//   cond            condition field Instr[31:28]
//   aluflags        {N,Z,C,V} from the ALU for this instruction
//   flagw           [1] writes N,Z ; [0] writes C,V
//   pcs/regw/memw   raw decoder strobes
//   nowrite         suppress regwrite (CMP and similar)
//   condex          condition passed (from flags_q)
//   cond_ill        cond == 4'b1111 while en
//   pcsrc/regwrite/memwrite  gated strobes
//   flags_q         registered {N,Z,C,V}
//   exec_cnt/skip_cnt  saturating counters (COND_PERF_EN only)
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       cond,
  input  logic [3:0]       aluflags,
  input  logic [1:0]       flagw,
  input  logic             pcs,
  input  logic             regw,
  input  logic             memw,
  input  logic             nowrite,
  output logic             condex,
  output logic             cond_ill,
  output logic             pcsrc,
  output logic             regwrite,
  output logic             memwrite,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  logic [3:0] flags_d;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // Condition is evaluated against stored flags only, so an instruction
  // never sees its own flag result.
  always_comb begin
    condex = 1'b0;
    case (cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  assign cond_ill = en & (cond == 4'b1111);
  assign pcsrc    = pcs & condex & en;
  assign regwrite = regw & ~nowrite & condex & en;
  assign memwrite = memw & condex & en;

  always_comb begin
    flags_d = flags_q;
    if (en && condex) begin
      if (flagw[1]) flags_d[3:2] = aluflags[3:2];
      if (flagw[0]) flags_d[1:0] = aluflags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

`ifdef COND_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] skip_q, skip_d;

  // Illegal cond has condex = 0, so it lands in the skipped count.
  always_comb begin
    exec_d = exec_q;
    skip_d = skip_q;
    if (en) begin
      if (condex) begin
        if (exec_q != CNT_MAX) exec_d = exec_q + 1'b1;
      end else begin
        if (skip_q != CNT_MAX) skip_d = skip_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exec_q <= '0;
      skip_q <= '0;
    end else begin
      exec_q <= exec_d;
      skip_q <= skip_d;
    end
  end

  assign exec_cnt = exec_q;
  assign skip_cnt = skip_q;
`else
  assign exec_cnt = '0;
  assign skip_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: the stimulus process applies one
// instruction per cycle and queues the expected outputs from a reference
// model; a monitor on the falling edge pops and compares.
module tb_cond_unit;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef COND_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, en, pcs, regw, memw, nowrite;
  logic [3:0]       cond, aluflags;
  logic [1:0]       flagw;
  logic             condex, cond_ill, pcsrc, regwrite, memwrite;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] exec_cnt, skip_cnt;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .cond(cond), .aluflags(aluflags),
    .flagw(flagw), .pcs(pcs), .regw(regw), .memw(memw), .nowrite(nowrite),
    .condex(condex), .cond_ill(cond_ill), .pcsrc(pcsrc), .regwrite(regwrite),
    .memwrite(memwrite), .flags_q(flags_q), .exec_cnt(exec_cnt),
    .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       condex, cond_ill, pcsrc, regwrite, memwrite;
    logic [3:0] flags;
    logic [3:0] exec_c, skip_c;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state
  bit [3:0] m_flags = 4'b0;
  int       m_exec  = 0;
  int       m_skip  = 0;

  function automatic bit passes(input bit [3:0] cc, input bit [3:0] f);
    bit N, Z, C, V;
    {N, Z, C, V} = f;
    case (cc)
      0:  return Z;
      1:  return !Z;
      2:  return C;
      3:  return !C;
      4:  return N;
      5:  return !N;
      6:  return V;
      7:  return !V;
      8:  return C && !Z;
      9:  return !C || Z;
      10: return N == V;
      11: return N != V;
      12: return !Z && (N == V);
      13: return Z || (N != V);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit rst, input bit e, input bit [3:0] cc,
                      input bit [3:0] af, input bit [1:0] fw, input bit p,
                      input bit r, input bit m, input bit nw, input bit chk);
    bit   ok;
    exp_t x;
    @(posedge clk); #1;
    reset = rst; en = e; cond = cc; aluflags = af; flagw = fw;
    pcs = p; regw = r; memw = m; nowrite = nw;
    ok = passes(cc, m_flags);
    x.condex   = ok;
    x.cond_ill = e && (cc == 4'hF);
    x.pcsrc    = p && ok && e;
    x.regwrite = r && !nw && ok && e;
    x.memwrite = m && ok && e;
    x.flags    = m_flags;
    x.exec_c   = PERF ? 4'(m_exec) : 4'd0;
    x.skip_c   = PERF ? 4'(m_skip) : 4'd0;
    if (chk) exp_q.push_back(x);
    // state after this edge
    if (rst) begin
      m_flags = 4'b0; m_exec = 0; m_skip = 0;
    end else if (e) begin
      if (ok) begin
        if (fw[1]) m_flags[3:2] = af[3:2];
        if (fw[0]) m_flags[1:0] = af[1:0];
        if (m_exec < CMAX) m_exec++;
      end else if (m_skip < CMAX) m_skip++;
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t x, a;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      a = {condex, cond_ill, pcsrc, regwrite, memwrite, flags_q, exec_cnt, skip_cnt};
      n_tests++;
      if (a !== x) begin
        n_fail++;
        $display("FAIL outputs cond=%h flags_q=%h got %h want %h (condex,ill,pc,rw,mw,flags,exec,skip)",
                 cond, flags_q, a, x);
      end
    end
  end

  task automatic do_reset();
    step(1, 1, 4'h0, 4'hF, 2'b11, 1, 1, 1, 0, 0);
    step(1, 1, 4'h0, 4'hF, 2'b11, 1, 1, 1, 0, 0);
  endtask

  initial begin
    reset = 1; en = 0; cond = 0; aluflags = 0; flagw = 0;
    pcs = 0; regw = 0; memw = 0; nowrite = 0;

    // reset state: flags 0, EQ fails, counters 0
    do_reset();
    step(0, 0, 4'h0, 4'h0, 2'b00, 1, 1, 1, 0, 1);

    // CMP then BEQ
    step(0, 1, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1, 1);
    step(0, 1, 4'h0, 4'b0000, 2'b00, 1, 0, 0, 0, 1);

    // partial write then GE
    step(0, 1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 1);
    step(0, 1, 4'hE, 4'h0, 2'b10, 0, 0, 0, 0, 1);
    step(0, 1, 4'hA, 4'h0, 2'b00, 1, 1, 1, 0, 1);

    // failed condition blocks flag updates
    step(0, 1, 4'hE, 4'h0, 2'b11, 0, 0, 0, 0, 1);
    step(0, 1, 4'h0, 4'hF, 2'b11, 0, 0, 1, 0, 1);
    step(0, 1, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 1);

    // sweep all flags x conds, with en=1 then en=0
    for (int f = 0; f < 16; f++) begin
      step(0, 1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 1);
      for (int c = 0; c < 16; c++) step(0, 1, 4'(c), 4'(~f), 2'b00, 1, 1, 1, 0, 1);
      for (int c = 0; c < 16; c++) step(0, 0, 4'(c), 4'(~f), 2'b11, 1, 1, 1, 0, 1);
    end

    // counter saturation: 20 executed, 3 skipped
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)  step(0, 1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    step(0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    @(negedge clk); #1;
    n_tests++;
    if (exec_cnt !== (PERF ? 4'd15 : 4'd0) || skip_cnt !== (PERF ? 4'd3 : 4'd0)) begin
      n_fail++;
      $display("FAIL counters exec=%0d skip=%0d want exec=%0d skip=%0d",
               exec_cnt, skip_cnt, PERF ? 15 : 0, PERF ? 3 : 0);
    end

    // random
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue has %0d entries, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
